// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types for the PPU host-write path.
//   table_e      - target table of a buffered host write
//   wr_entry_t   - one queued write {table, index, data}
//   VACTIVE/VTOTAL - VGA line counts used for the default commit window
package ppu_pkg;

    typedef enum logic [1:0] {
        TBL_ATTR    = 2'd0,
        TBL_COLOR   = 2'd1,
        TBL_PATTERN = 2'd2,
        TBL_SPRITE  = 2'd3
    } table_e;

    typedef struct packed {
        table_e      tbl;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_entry_t;

    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    // Bus address that clears the window interrupt (when the IRQ is built in).
    localparam logic [15:0] IRQ_CLR_ADDR = 16'hFFFF;

    // Any selector above 2 falls through to the sprite table.
    function automatic table_e decode_table(input logic [3:0] sel);
        case (sel)
            4'h0:    return TBL_ATTR;
            4'h1:    return TBL_COLOR;
            4'h2:    return TBL_PATTERN;
            default: return TBL_SPRITE;
        endcase
    endfunction

    function automatic logic [3:0] table_we(input table_e t);
        return 4'b0001 << t;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational (fall-through) read data.
//   push/din   - write an entry when not full (ignored when full)
//   pop/dout   - dout is the head entry; pop advances when not empty
//   full/empty/count - occupancy status, count in 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ppu_write_scheduler.sv
// ppu_write_scheduler: buffers host writes to the PPU tables and commits
// them only while vcount is inside the blanking window [WIN_FIRST, WIN_LAST].
//   clk, reset_n            - 50 MHz clock, async active-low reset
//   chipselect/write/address/writedata/waitrequest - Avalon slave write port
//   vcount                  - current VGA line
//   mem_we/mem_addr/mem_data - registered table write port (one-hot we)
//   level                   - FIFO occupancy
//   frame_done              - pulse when the queue empties inside a window
//   irq                     - window-open interrupt, present only when
//                             WSCHED_IRQ_EN is defined (cleared by a write
//                             to 0xFFFF, which is then not queued)
module ppu_write_scheduler
    import ppu_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIN_FIRST = VACTIVE,
    parameter int WIN_LAST  = VTOTAL - 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [15:0]             address,
    input  logic [31:0]             writedata,
    output logic                    waitrequest,
    input  logic [9:0]              vcount,
    output logic [3:0]              mem_we,
    output logic [11:0]             mem_addr,
    output logic [31:0]             mem_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    frame_done
`ifdef WSCHED_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int EW = $bits(wr_entry_t);

    typedef enum logic [1:0] {ST_WAIT, ST_DRAIN, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       mem_we_q, mem_we_d;
    logic [11:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             frame_done_q, frame_done_d;

    logic             win, bus_wr, push, pop, full, empty, fifo_last;
    wr_entry_t        push_entry, pop_entry;
    logic [EW-1:0]    fifo_dout;

    assign win    = (vcount >= 10'(WIN_FIRST)) && (vcount <= 10'(WIN_LAST));
    assign bus_wr = chipselect && write;

`ifdef WSCHED_IRQ_EN
    logic irq_q, irq_d, irq_clr, irq_set;
    // The clear address is a control register, not a table write.
    assign irq_clr = bus_wr && !full && (address == IRQ_CLR_ADDR);
    assign push    = bus_wr && !full && (address != IRQ_CLR_ADDR);
    assign irq_set = (state_q == ST_WAIT) && win;
    // Set has priority so a stale clear cannot swallow a new window.
    assign irq_d   = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    assign irq     = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end
`else
    assign push = bus_wr && !full;
`endif

    assign waitrequest = full;

    assign push_entry = '{tbl: decode_table(address[15:12]),
                          addr: address[11:0],
                          data: writedata};
    assign pop_entry  = wr_entry_t'(fifo_dout);

    // Pops are gated by win so nothing leaves the FIFO once the window closes;
    // an entry popped on the final window cycle still lands one cycle later.
    assign pop = (state_q != ST_WAIT) && win && !empty;

    // Queue is (or will be, after this cycle) empty: the drain is complete.
    assign fifo_last = empty || (pop && !push && (level == 1));

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (empty),
        .count   (level)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (win) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!win) begin
                    state_d = ST_WAIT;
                end else if (fifo_last) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!win) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        mem_we_d   = 4'b0000;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (pop) begin
            mem_we_d   = table_we(pop_entry.tbl);
            mem_addr_d = pop_entry.addr;
            mem_data_d = pop_entry.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Scoreboard bench for ppu_write_scheduler: stimulus pushes the expected
// table write for each accepted entry; a negedge monitor pops and compares
// whenever mem_we is non-zero.
module tb_ppu_write_scheduler;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          chipselect, write;
    logic [15:0]   address;
    logic [31:0]   writedata;
    logic          waitrequest;
    logic [9:0]    vcount;
    logic [3:0]    mem_we;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [LW-1:0] level;
    logic          frame_done;
`ifdef WSCHED_IRQ_EN
    logic          irq;
`endif

    ppu_write_scheduler #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .vcount      (vcount),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .level       (level),
        .frame_done  (frame_done)
`ifdef WSCHED_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int cyc = 0;
    int commit_cnt = 0, fd_cnt = 0;
    int last_commit_cyc = -1, last_fd_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every committed table write must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we != 4'b0000) begin
                commit_cnt++;
                last_commit_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit we=%b addr=%h data=%h", mem_we, mem_addr, mem_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_we",   {60'd0, mem_we},   {60'd0, e.we});
                    chk("commit_addr", {52'd0, mem_addr}, {52'd0, e.addr});
                    chk("commit_data", {32'd0, mem_data}, {32'd0, e.data});
                end
            end
            if (frame_done) begin
                fd_cnt++;
                last_fd_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus write; exp_commit=0 means the entry must never reach a table.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] exp_we, input bit exp_commit);
        int w = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        while (waitrequest && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) chk("bus_write_timeout", 64'(w), 64'd0);
        if (exp_commit) sb.push_back('{we: exp_we, addr: a[11:0], data: d});
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic wait_commits(input int n, input int budget, input string name);
        int w = 0;
        while (commit_cnt < n && w < budget) begin
            tick();
            w++;
        end
        chk(name, 64'(commit_cnt), 64'(n));
    endtask

    logic [3:0] nib_tab [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9};
    logic [3:0] we_tab  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000};

    initial begin
        int k, base, fdb, w;
        rst_n = 1'b0; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0; vcount = '0;
        tick(3);
        chk("rst_level",       64'(level),       64'd0);
        chk("rst_waitrequest", 64'(waitrequest), 64'd0);
        chk("rst_mem_we",      64'(mem_we),      64'd0);
        chk("rst_frame_done",  64'(frame_done),  64'd0);
`ifdef WSCHED_IRQ_EN
        chk("rst_irq",         64'(irq),         64'd0);
`endif
        rst_n = 1'b1;
        tick(2);

        // 1: single pattern write held until the window opens.
        vcount = 10'd100;
        bus_write(16'h2005, 32'hDEADBEEF, 4'b0100, 1'b1);
        tick(5);
        chk("t1_level_held", 64'(level), 64'd1);
        chk("t1_no_commit",  64'(commit_cnt), 64'd0);
        k = cyc;
        vcount = 10'd480;
        wait_commits(1, 20, "t1_commit_count");
        chk("t1_commit_cycle", 64'(last_commit_cyc), 64'(k + 2));
        chk("t1_fd_cycle",     64'(last_fd_cyc),     64'(k + 2));
        tick(5);
        chk("t1_fd_once", 64'(fd_cnt), 64'd1);
        vcount = 10'd0;
        tick(2);

        // 2: fill the FIFO, 17th write is held by waitrequest.
        vcount = 10'd100;
        base = commit_cnt; fdb = fd_cnt;
        for (int i = 0; i < 16; i++)
            bus_write({nib_tab[i % 5], 12'(i * 3 + 7)}, 32'hA500_0000 | 32'(i), we_tab[i % 5], 1'b1);
        chk("t2_level_full", 64'(level),       64'(DEPTH));
        chk("t2_waitreq",    64'(waitrequest), 64'd1);
        chipselect = 1'b1; write = 1'b1;
        address = {nib_tab[16 % 5], 12'(16 * 3 + 7)}; writedata = 32'hA500_0010;
        tick(3);
        chk("t2_waitreq_held", 64'(waitrequest), 64'd1);
        chk("t2_level_held",   64'(level),       64'(DEPTH));
        chk("t2_no_commit",    64'(commit_cnt),  64'(base));
        sb.push_back('{we: we_tab[16 % 5], addr: address[11:0], data: writedata});
        vcount = 10'd480;
        w = 0;
        while (waitrequest && w < 50) begin
            tick();
            w++;
        end
        chk("t2_waitreq_drops", 64'(waitrequest), 64'd0);
        tick();
        chipselect = 1'b0; write = 1'b0;
        wait_commits(base + 17, 100, "t2_commit_count");
        tick(2);
        chk("t2_level_empty", 64'(level),  64'd0);
        chk("t2_fd",          64'(fd_cnt), 64'(fdb + 1));
        vcount = 10'd0;
        tick(2);

`ifndef WSCHED_IRQ_EN
        // 0xFFFF is an ordinary sprite write to index 0xFFF.
        vcount = 10'd100;
        base = commit_cnt;
        bus_write(16'hFFFF, 32'h0BADF00D, 4'b1000, 1'b1);
        vcount = 10'd480;
        wait_commits(base + 1, 20, "ffff_sprite_commit");
        vcount = 10'd0;
        tick(2);
`endif

        // 3: window closes mid-drain; remainder commits next window.
        vcount = 10'd100;
        base = commit_cnt; fdb = fd_cnt;
        bus_write(16'h0011, 32'h3333_0001, 4'b0001, 1'b1);
        bus_write(16'h2022, 32'h3333_0002, 4'b0100, 1'b1);
        bus_write(16'h5033, 32'h3333_0003, 4'b1000, 1'b1);
        vcount = 10'd523;
        tick(2);
        vcount = 10'd524;
        tick(4);
        chk("t3_partial_commits", 64'(commit_cnt), 64'(base + 1));
        chk("t3_level_left",      64'(level),      64'd2);
        chk("t3_no_fd",           64'(fd_cnt),     64'(fdb));
        vcount = 10'd0;
        tick(3);
        chk("t3_still_held", 64'(commit_cnt), 64'(base + 1));
        vcount = 10'd480;
        wait_commits(base + 3, 20, "t3_commit_count");
        tick(3);
        chk("t3_fd_next", 64'(fd_cnt), 64'(fdb + 1));

        // 4: write during DONE commits two cycles later, no extra frame_done.
        vcount = 10'd500;
        base = commit_cnt; fdb = fd_cnt;
        k = cyc;
        bus_write(16'h1003, 32'hC0FFEE03, 4'b0010, 1'b1);
        wait_commits(base + 1, 20, "t4_commit_count");
        chk("t4_commit_cycle", 64'(last_commit_cyc), 64'(k + 2));
        tick(3);
        chk("t4_no_second_fd", 64'(fd_cnt), 64'(fdb));
        vcount = 10'd0;
        tick(2);

        // 5: reset mid-drain discards the queued entries.
        vcount = 10'd100;
        base = commit_cnt;
        bus_write(16'h0100, 32'h5555_0000, 4'b0001, 1'b1);
        for (int i = 1; i < 5; i++)
            bus_write(16'h0100 + 16'(i), 32'h5555_0000 + 32'(i), 4'b0001, 1'b0);
        vcount = 10'd480;
        tick(2);
        @(negedge clk);
        #1;
        chk("t5_first_commit", 64'(commit_cnt), 64'(base + 1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_level",  64'(level),       64'd0);
        chk("t5_rst_mem_we", 64'(mem_we),      64'd0);
        chk("t5_rst_waitrq", 64'(waitrequest), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t5_no_commit_after", 64'(commit_cnt), 64'(base + 1));
        chk("t5_level_after",     64'(level),      64'd0);

`ifdef WSCHED_IRQ_EN
        // 6: irq set at window open, cleared by 0xFFFF, set wins a tie.
        vcount = 10'd0;
        tick(2);
        base = commit_cnt;
        bus_write(16'h0200, 32'h6666_0000, 4'b0001, 1'b1);
        bus_write(16'hFFFF, 32'h0, 4'b0000, 1'b0);
        chk("t6_irq_cleared", 64'(irq),   64'd0);
        chk("t6_level_kept",  64'(level), 64'd1);
        vcount = 10'd480;
        tick();
        chk("t6_irq_set", 64'(irq), 64'd1);
        wait_commits(base + 1, 20, "t6_commit_count");
        vcount = 10'd0;
        tick(2);
        bus_write(16'hFFFF, 32'h0, 4'b0000, 1'b0);
        chk("t6_irq_cleared2", 64'(irq), 64'd0);
        chipselect = 1'b1; write = 1'b1; address = 16'hFFFF; writedata = '0;
        vcount = 10'd480;
        tick();
        chipselect = 1'b0; write = 1'b0;
        chk("t6_set_wins", 64'(irq),   64'd1);
        chk("t6_tie_level", 64'(level), 64'd0);
        vcount = 10'd0;
        tick(2);
`endif

        tick(5);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
